// File: rtl/reg_wr_arb.sv
// Round-robin write arbiter that shares one loadable register between four requesters.
// Define REG_ARB_LOCK_EN to compile in the HOLD state and per-requester burst locking.
module reg_wr_arb #(
  parameter int unsigned n = 8
) (
  input  logic           clk,
  input  logic           clr,
  input  logic [3:0]     req,
  input  logic [4*n-1:0] wdata,
  input  logic [3:0]     lock,
  output logic [3:0]     ack,
  output logic           reg_ld,
  output logic [n-1:0]   reg_din,
  output logic [1:0]     wr_id,
  output logic           busy
);

`ifdef REG_ARB_LOCK_EN
  typedef enum logic [1:0] {StIdle, StWrite, StHold} state_e;
`else
  typedef enum logic [1:0] {StIdle, StWrite} state_e;
  logic unused_lock;
  assign unused_lock = ^lock;
`endif

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] gnt_q, gnt_d;
  logic [1:0] wr_id_q, wr_id_d;
  logic [1:0] win;
  logic [1:0] cand;
  logic       write;
  logic       write_en;

  // Walk the search order backwards so the earliest candidate (ptr+1) has the final say.
  always_comb begin
    win  = ptr_q;
    cand = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr_q + 2'(k + 1);
      if (req[cand]) win = cand;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    wr_id_d = wr_id_q;
    write   = 1'b0;
    case (state_q)
      StIdle: begin
        if (|req) begin
          gnt_d   = win;
          ptr_d   = win;
          state_d = StWrite;
        end
      end
      StWrite: begin
        write   = 1'b1;
        wr_id_d = gnt_q;
`ifdef REG_ARB_LOCK_EN
        state_d = lock[gnt_q] ? StHold : StIdle;
`else
        state_d = StIdle;
`endif
      end
`ifdef REG_ARB_LOCK_EN
      StHold: begin
        if (!lock[gnt_q]) begin
          state_d = StIdle;
        end else if (req[gnt_q]) begin
          write   = 1'b1;
          wr_id_d = gnt_q;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= StIdle;
      ptr_q   <= 2'd3;
      gnt_q   <= 2'd0;
      wr_id_q <= 2'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      wr_id_q <= wr_id_d;
    end
  end

  // A cycle with clr high must never load, even when the state says WRITE or HOLD.
  assign write_en = write & ~clr;
  assign reg_ld   = write_en;
  assign ack      = write_en ? (4'b0001 << gnt_q) : 4'b0000;
  assign reg_din  = wdata[gnt_q*n +: n];
  assign wr_id    = wr_id_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_reg_wr_arb.sv
// Directed table-driven bench for reg_wr_arb, plus lock/no-lock burst sequences.
module tb_reg_wr_arb;

  localparam logic [31:0] W0 = {8'h44, 8'h33, 8'h22, 8'hA5};
  localparam logic [31:0] W1 = {8'h44, 8'h33, 8'h3C, 8'hA5};

  logic        clk = 1'b0;
  logic        clr;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  lock;
  logic [3:0]  ack;
  logic        reg_ld;
  logic [7:0]  reg_din;
  logic [1:0]  wr_id;
  logic        busy;
  logic [7:0]  shared_reg = 8'h00;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        clr;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  ack;
    logic        ld;
    logic [7:0]  din;
    logic [1:0]  wr_id;
    logic        busy;
  } vec_t;

  vec_t tbl[23];

  logic [3:0] lk_ack[8];
  logic       lk_busy[8];

  reg_wr_arb #(.n(8)) dut (
    .clk     (clk),
    .clr     (clr),
    .req     (req),
    .wdata   (wdata),
    .lock    (lock),
    .ack     (ack),
    .reg_ld  (reg_ld),
    .reg_din (reg_din),
    .wr_id   (wr_id),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Stand-in for the shared reg_nb register.
  always_ff @(posedge clk) begin
    if (reg_ld) shared_reg <= reg_din;
  end

  function automatic vec_t mk(input logic c, input logic [3:0] r, input logic [31:0] w,
                              input logic [3:0] a, input logic l, input logic [7:0] d,
                              input logic [1:0] id, input logic b);
    vec_t v;
    v.clr = c; v.req = r; v.wdata = w; v.ack = a;
    v.ld = l; v.din = d; v.wr_id = id; v.busy = b;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input logic c, input logic [3:0] r, input logic [3:0] l,
                       input logic [31:0] w);
    @(posedge clk);
    #1;
    clr = c; req = r; lock = l; wdata = w;
    @(negedge clk);
  endtask

  initial begin
    tbl[0]  = mk(1'b1, 4'b0000, W0, 4'b0000, 1'b0, 8'hA5, 2'd0, 1'b0);
    tbl[1]  = mk(1'b0, 4'b0001, W0, 4'b0000, 1'b0, 8'hA5, 2'd0, 1'b0);
    tbl[2]  = mk(1'b0, 4'b0000, W0, 4'b0001, 1'b1, 8'hA5, 2'd0, 1'b1);
    tbl[3]  = mk(1'b0, 4'b0000, W0, 4'b0000, 1'b0, 8'hA5, 2'd0, 1'b0);
    tbl[4]  = mk(1'b1, 4'b0000, W0, 4'b0000, 1'b0, 8'hA5, 2'd0, 1'b0);
    tbl[5]  = mk(1'b0, 4'b1111, W0, 4'b0000, 1'b0, 8'hA5, 2'd0, 1'b0);
    tbl[6]  = mk(1'b0, 4'b1111, W0, 4'b0001, 1'b1, 8'hA5, 2'd0, 1'b1);
    tbl[7]  = mk(1'b0, 4'b1111, W0, 4'b0000, 1'b0, 8'hA5, 2'd0, 1'b0);
    tbl[8]  = mk(1'b0, 4'b1111, W0, 4'b0010, 1'b1, 8'h22, 2'd0, 1'b1);
    tbl[9]  = mk(1'b0, 4'b1111, W0, 4'b0000, 1'b0, 8'h22, 2'd1, 1'b0);
    tbl[10] = mk(1'b0, 4'b1111, W0, 4'b0100, 1'b1, 8'h33, 2'd1, 1'b1);
    tbl[11] = mk(1'b0, 4'b1111, W0, 4'b0000, 1'b0, 8'h33, 2'd2, 1'b0);
    tbl[12] = mk(1'b0, 4'b0000, W0, 4'b1000, 1'b1, 8'h44, 2'd2, 1'b1);
    tbl[13] = mk(1'b0, 4'b0001, W0, 4'b0000, 1'b0, 8'h44, 2'd3, 1'b0);
    tbl[14] = mk(1'b0, 4'b0000, W0, 4'b0001, 1'b1, 8'hA5, 2'd3, 1'b1);
    tbl[15] = mk(1'b0, 4'b0101, W0, 4'b0000, 1'b0, 8'hA5, 2'd0, 1'b0);
    tbl[16] = mk(1'b0, 4'b0101, W0, 4'b0100, 1'b1, 8'h33, 2'd0, 1'b1);
    tbl[17] = mk(1'b0, 4'b0101, W0, 4'b0000, 1'b0, 8'h33, 2'd2, 1'b0);
    tbl[18] = mk(1'b0, 4'b0000, W0, 4'b0001, 1'b1, 8'hA5, 2'd2, 1'b1);
    tbl[19] = mk(1'b0, 4'b0000, W0, 4'b0000, 1'b0, 8'hA5, 2'd0, 1'b0);
    tbl[20] = mk(1'b0, 4'b0010, W1, 4'b0000, 1'b0, 8'hA5, 2'd0, 1'b0);
    tbl[21] = mk(1'b1, 4'b0000, W1, 4'b0000, 1'b0, 8'h3C, 2'd0, 1'b1);
    tbl[22] = mk(1'b0, 4'b0000, W1, 4'b0000, 1'b0, 8'hA5, 2'd0, 1'b0);

`ifdef REG_ARB_LOCK_EN
    lk_ack  = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0100};
    lk_busy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
`else
    lk_ack  = '{4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b0010, 4'b0000, 4'b0100};
    lk_busy = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`endif

    clr = 1'b1; req = '0; lock = '0; wdata = W0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 23; i++) begin
      apply(tbl[i].clr, tbl[i].req, 4'b0000, tbl[i].wdata);
      check($sformatf("row%0d ack", i), 32'(ack), 32'(tbl[i].ack));
      check($sformatf("row%0d reg_ld", i), 32'(reg_ld), 32'(tbl[i].ld));
      check($sformatf("row%0d reg_din", i), 32'(reg_din), 32'(tbl[i].din));
      check($sformatf("row%0d wr_id", i), 32'(wr_id), 32'(tbl[i].wr_id));
      check($sformatf("row%0d busy", i), 32'(busy), 32'(tbl[i].busy));
    end
    // The write cut short by clr must not reach the register.
    check("clr discards write", 32'(shared_reg), 32'h0000_00A5);

    // Requester 1 asks with lock high while requester 2 waits, then both drop lock/req[1].
    for (int c = 0; c < 8; c++) begin
      if (c < 5) apply(1'b0, 4'b0110, 4'b0010, W0);
      else       apply(1'b0, 4'b0100, 4'b0000, W0);
      check($sformatf("burst c%0d ack", c), 32'(ack), 32'(lk_ack[c]));
      check($sformatf("burst c%0d reg_ld", c), 32'(reg_ld), 32'(|lk_ack[c]));
      check($sformatf("burst c%0d busy", c), 32'(busy), 32'(lk_busy[c]));
    end
    apply(1'b0, 4'b0000, 4'b0000, W0);
    check("burst end wr_id", 32'(wr_id), 32'd2);
    check("burst end busy", 32'(busy), 32'd0);
    check("burst end register", 32'(shared_reg), 32'h0000_0033);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
